// File: rtl/control_unit_if.sv
// Bus between the control unit and its datapath/program memory.
// The control unit side is the master: it issues the program address and
// the register/ULA control codes, and it receives the fetched instruction,
// the ULA zero status and the start request.
interface control_unit_if;
  logic              start;   // begin execution from address 0
  logic [6:0]        instr;   // {opcode[6:4], imm[3:0]} addressed by pc
  logic              status;  // ULA result is zero
  logic [3:0]        pc;      // program memory address
  logic signed [3:0] imm;     // immediate for RegistratorX
  logic [2:0]        tx;      // RegistratorX control
  logic [2:0]        ty;      // RegistratorY control
  logic [2:0]        tz;      // RegistratorZ control
  logic [2:0]        tula;    // ULA operation select
  logic              busy;    // FETCH or EXEC in progress
  logic              done;    // one-cycle pulse on entering HALT

  modport master (
    input  start, instr, status,
    output pc, imm, tx, ty, tz, tula, busy, done
  );

  modport slave (
    output start, instr, status,
    input  pc, imm, tx, ty, tz, tula, busy, done
  );
endinterface

// File: rtl/control_unit.sv
// Control unit for a small accumulator-style datapath.
// A four-state FSM (IDLE/FETCH/EXEC/HALT) fetches one instruction per
// FETCH cycle into ir, then drives the register and ULA controls for one
// EXEC cycle. Controls are decoded combinationally from the registered
// state and ir, so they are at their idle defaults everywhere but EXEC.
module control_unit (
  input  logic          clk_i,
  input  logic          rst_i,
  control_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDX  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MOVZ = 3'b100,
    OP_CLR  = 3'b101,
    OP_BRZ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  localparam logic [2:0] REG_HOLD  = 3'b000;
  localparam logic [2:0] REG_LOAD  = 3'b001;
  localparam logic [2:0] REG_CLEAR = 3'b010;
  localparam logic [2:0] ULA_ADD   = 3'b000;
  localparam logic [2:0] ULA_SUB   = 3'b001;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [6:0]  ir_q, ir_d;
  logic        zflag_q, zflag_d;
  logic        done_q, done_d;

  opcode_e     op;
  logic [2:0]  tx, ty, tz, tula;
  logic signed [3:0] imm;
  logic        busy;

  assign op = opcode_e'(ir_q[6:4]);

  // State register; reset wins over everything, including start.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 7'd0;
      zflag_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zflag_q <= zflag_d;
      done_q  <= done_d;
    end
  end

  // Next-state, pc/ir/zflag update and control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zflag_d = zflag_q;
    done_d  = 1'b0;
    tx      = REG_HOLD;
    ty      = REG_HOLD;
    tz      = REG_HOLD;
    tula    = ULA_ADD;
    imm     = 4'sd0;
    busy    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          pc_d    = 4'd0;
        end
      end

      FETCH: begin
        busy    = 1'b1;
        ir_d    = bus.instr;
        state_d = EXEC;
      end

      EXEC: begin
        busy    = 1'b1;
        state_d = FETCH;
        // Sequential flow wraps 15 -> 0 naturally in 4 bits.
        pc_d    = pc_q + 4'd1;
        case (op)
          OP_NOP: ;
          OP_LDX: begin
            tx  = REG_LOAD;
            imm = signed'(ir_q[3:0]);
          end
          OP_ADD: begin
            tula    = ULA_ADD;
            ty      = REG_LOAD;
            zflag_d = bus.status;
          end
          OP_SUB: begin
            tula    = ULA_SUB;
            ty      = REG_LOAD;
            zflag_d = bus.status;
          end
          OP_MOVZ: tz = REG_LOAD;
          OP_CLR: begin
            tx      = REG_CLEAR;
            ty      = REG_CLEAR;
            tz      = REG_CLEAR;
            zflag_d = 1'b0;
          end
          OP_BRZ: begin
            if (zflag_q) pc_d = ir_q[3:0];
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
            done_d  = 1'b1;
          end
        endcase
      end

      HALT: begin
        if (bus.start) begin
          state_d = FETCH;
          pc_d    = 4'd0;
          zflag_d = 1'b0;
        end
      end
    endcase
  end

  assign bus.pc   = pc_q;
  assign bus.imm  = imm;
  assign bus.tx   = tx;
  assign bus.ty   = ty;
  assign bus.tz   = tz;
  assign bus.tula = tula;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Each step pushes the expected outputs
// for the coming cycle onto a scoreboard queue, advances one clock, and
// pops/compares against the DUT on the falling edge.
module tb_control_unit;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, CLEAR = 3'b010;
  localparam logic [2:0] ADD  = 3'b000, SUB  = 3'b001;

  localparam logic [6:0] I_NOP  = 7'b000_0000;
  localparam logic [6:0] I_LDX5 = 7'b001_0101;
  localparam logic [6:0] I_ADD  = 7'b010_0000;
  localparam logic [6:0] I_SUB  = 7'b011_0000;
  localparam logic [6:0] I_MOVZ = 7'b100_0000;
  localparam logic [6:0] I_CLR  = 7'b101_0000;
  localparam logic [6:0] I_BRZ9 = 7'b110_1001;
  localparam logic [6:0] I_BRZ2 = 7'b110_0010;
  localparam logic [6:0] I_HALT = 7'b111_0000;

  typedef struct {
    string      tag;
    logic [3:0] pc;
    logic [3:0] imm;
    logic [2:0] tx, ty, tz, tula;
    logic       busy, done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] prog [16];
  exp_t sb_q [$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  control_unit_if bus ();

  control_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr = prog[bus.pc];

  task automatic compare(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input string tag, input logic [3:0] pc,
                              input logic busy, input logic done);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.imm  = 4'd0;
    e.tx   = HOLD;
    e.ty   = HOLD;
    e.tz   = HOLD;
    e.tula = ADD;
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    compare({got.tag, ".pc"},   bus.pc,          got.pc);
    compare({got.tag, ".imm"},  bus.imm,         got.imm);
    compare({got.tag, ".tx"},   {1'b0, bus.tx},  {1'b0, got.tx});
    compare({got.tag, ".ty"},   {1'b0, bus.ty},  {1'b0, got.ty});
    compare({got.tag, ".tz"},   {1'b0, bus.tz},  {1'b0, got.tz});
    compare({got.tag, ".tula"}, {1'b0, bus.tula}, {1'b0, got.tula});
    compare({got.tag, ".busy"}, {3'b0, bus.busy}, {3'b0, got.busy});
    compare({got.tag, ".done"}, {3'b0, bus.done}, {3'b0, got.done});
  endtask

  task automatic fetch(input logic [3:0] pc);
    step(mk("fetch", pc, 1'b1, 1'b0));
  endtask

  task automatic exec(input string tag, input logic [3:0] pc,
                      input logic [2:0] tx, input logic [2:0] ty, input logic [2:0] tz,
                      input logic [2:0] tula, input logic [3:0] imm);
    exp_t e;
    e      = mk(tag, pc, 1'b1, 1'b0);
    e.tx   = tx;
    e.ty   = ty;
    e.tz   = tz;
    e.tula = tula;
    e.imm  = imm;
    step(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = I_NOP;
  endtask

  initial begin
    bit seen;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.status = 1'b0;
    clear_prog();

    // Reset state, reset priority over start, idle hold.
    step(mk("reset", 4'd0, 1'b0, 1'b0));
    bus.start = 1'b1;
    step(mk("rst_over_start", 4'd0, 1'b0, 1'b0));
    rst = 1'b0;
    bus.start = 1'b0;
    step(mk("idle_hold", 4'd0, 1'b0, 1'b0));

    // LDX 5, ADD, MOVZ, HALT; start asserted mid-run must be ignored.
    prog[0] = I_LDX5; prog[1] = I_ADD; prog[2] = I_MOVZ; prog[3] = I_HALT;
    bus.start = 1'b1;
    fetch(4'd0);
    bus.start = 1'b0;
    exec("ldx", 4'd0, LOAD, HOLD, HOLD, ADD, 4'd5);
    fetch(4'd1);
    exec("add", 4'd1, HOLD, LOAD, HOLD, ADD, 4'd0);
    fetch(4'd2);
    bus.start = 1'b1;
    exec("movz_start_ignored", 4'd2, HOLD, HOLD, LOAD, ADD, 4'd0);
    fetch(4'd3);
    bus.start = 1'b0;
    exec("halt_exec", 4'd3, HOLD, HOLD, HOLD, ADD, 4'd0);
    step(mk("halt_done", 4'd3, 1'b0, 1'b1));
    step(mk("halt_stay", 4'd3, 1'b0, 1'b0));

    // SUB with status=1 then BRZ 9: branch taken.
    clear_prog();
    prog[0] = I_SUB; prog[1] = I_BRZ9; prog[2] = I_HALT; prog[9] = I_HALT;
    bus.start = 1'b1;
    fetch(4'd0);
    bus.start  = 1'b0;
    bus.status = 1'b1;
    exec("sub_z1", 4'd0, HOLD, LOAD, HOLD, SUB, 4'd0);
    fetch(4'd1);
    bus.status = 1'b0;
    exec("brz_taken", 4'd1, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd9);
    exec("halt9", 4'd9, HOLD, HOLD, HOLD, ADD, 4'd0);
    step(mk("halt9_done", 4'd9, 1'b0, 1'b1));

    // Restart clears zflag; CLR clears it; SUB with status=0 clears it.
    clear_prog();
    prog[0] = I_BRZ9; prog[1] = I_SUB; prog[2] = I_CLR; prog[3] = I_BRZ2;
    prog[4] = I_SUB;  prog[5] = I_SUB; prog[6] = I_BRZ9; prog[7] = I_HALT;
    bus.start = 1'b1;
    fetch(4'd0);
    bus.start = 1'b0;
    exec("brz_after_restart", 4'd0, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd1);
    bus.status = 1'b1;
    exec("sub_set_z", 4'd1, HOLD, LOAD, HOLD, SUB, 4'd0);
    fetch(4'd2);
    bus.status = 1'b0;
    exec("clr", 4'd2, CLEAR, CLEAR, CLEAR, ADD, 4'd0);
    fetch(4'd3);
    exec("brz_after_clr", 4'd3, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd4);
    bus.status = 1'b1;
    exec("sub_set_z2", 4'd4, HOLD, LOAD, HOLD, SUB, 4'd0);
    fetch(4'd5);
    bus.status = 1'b0;
    exec("sub_z0", 4'd5, HOLD, LOAD, HOLD, SUB, 4'd0);
    fetch(4'd6);
    exec("brz_not_taken", 4'd6, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd7);
    exec("halt7", 4'd7, HOLD, HOLD, HOLD, ADD, 4'd0);
    step(mk("halt7_done", 4'd7, 1'b0, 1'b1));

    // Sixteen NOPs: pc wraps 15 -> 0.
    clear_prog();
    bus.start = 1'b1;
    fetch(4'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exec("nop", 4'(i), HOLD, HOLD, HOLD, ADD, 4'd0);
      fetch(4'(i + 1));
    end

    // Reset during EXEC of ADD; status=1 must not reach zflag.
    prog[1] = I_ADD;
    exec("nop_pre", 4'd0, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd1);
    bus.status = 1'b1;
    exec("add_pre_rst", 4'd1, HOLD, LOAD, HOLD, ADD, 4'd0);
    rst = 1'b1;
    bus.start = 1'b1;
    step(mk("rst_mid_exec", 4'd0, 1'b0, 1'b0));
    step(mk("rst_start_ignored", 4'd0, 1'b0, 1'b0));
    rst = 1'b0;
    bus.start  = 1'b0;
    bus.status = 1'b0;
    step(mk("idle_after_rst", 4'd0, 1'b0, 1'b0));

    // After reset zflag is 0, so BRZ falls through to HALT at pc 1.
    clear_prog();
    prog[0] = I_BRZ9; prog[1] = I_HALT;
    bus.start = 1'b1;
    fetch(4'd0);
    bus.start = 1'b0;
    exec("brz_post_rst", 4'd0, HOLD, HOLD, HOLD, ADD, 4'd0);
    fetch(4'd1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    compare("done_within_budget", {3'b0, seen}, 4'd1);
    compare("done_pc", bus.pc, 4'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
